// File: rtl/alu_matrix_loader_module_if.sv
// Operand-loader bus: start/size request, byte stream with valid/ready, assembled operands and status.
interface alu_matrix_loader_module_if #(
    parameter int DIM    = 5,
    parameter int ELEM_W = 8
);
    localparam int FLAT_W = DIM * DIM * ELEM_W;

    logic              start_load;
    logic [2:0]        size;
    logic [ELEM_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;
    logic [FLAT_W-1:0] A_flat;
    logic [FLAT_W-1:0] B_flat;
    logic              busy;
    logic              load_done;
    logic              size_error;

    modport master (
        output start_load, size, data_in, data_valid,
        input  data_ready, A_flat, B_flat, busy, load_done, size_error
    );

    modport slave (
        input  start_load, size, data_in, data_valid,
        output data_ready, A_flat, B_flat, busy, load_done, size_error
    );
endinterface

// File: rtl/alu_matrix_loader_module.sv
// Assembles two row-major NxN byte matrices (N=2..DIM) from a valid/ready stream; first transfer the cycle
// after start_load, load_done the cycle after the last B byte; data_ready is high only while loading.
module alu_matrix_loader_module #(
    parameter int DIM    = 5,
    parameter int ELEM_W = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    alu_matrix_loader_module_if.slave bus
);
    localparam int FLAT_W = DIM * DIM * ELEM_W;
    localparam int ROW_W  = DIM * ELEM_W;
    localparam int POS_W  = $clog2(FLAT_W);

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        row, col, n_lat;
    logic [FLAT_W-1:0] a_q, b_q;
    logic              size_error_q;
    logic              size_ok, xfer, last_elem;
    logic [POS_W-1:0]  pos;

    assign size_ok   = (bus.size >= 3'd2) && (bus.size <= 3'(DIM));
    assign xfer      = bus.data_valid && bus.data_ready;
    assign last_elem = (row == n_lat - 3'd1) && (col == n_lat - 3'd1);
    assign pos       = POS_W'(int'(row) * ROW_W + int'(col) * ELEM_W);

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        bus.data_ready = 1'b0;
        bus.busy       = 1'b1;
        bus.load_done  = 1'b0;
        case (state_q)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start_load && size_ok) state_d = LOAD_A;
            end
            LOAD_A: begin
                bus.data_ready = 1'b1;
                if (bus.data_valid && last_elem) state_d = LOAD_B;
            end
            LOAD_B: begin
                bus.data_ready = 1'b1;
                if (bus.data_valid && last_elem) state_d = DONE;
            end
            DONE: begin
                bus.load_done = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operands are cleared only when a legal load is accepted, so they hold through DONE and IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_q          <= '0;
            b_q          <= '0;
            row          <= '0;
            col          <= '0;
            n_lat        <= '0;
            size_error_q <= 1'b0;
        end else begin
            size_error_q <= 1'b0;
            if (state_q == IDLE && bus.start_load) begin
                if (size_ok) begin
                    n_lat <= bus.size;
                    a_q   <= '0;
                    b_q   <= '0;
                    row   <= '0;
                    col   <= '0;
                end else begin
                    size_error_q <= 1'b1;
                end
            end
            if (xfer) begin
                if (state_q == LOAD_A) a_q[pos +: ELEM_W] <= bus.data_in;
                else                   b_q[pos +: ELEM_W] <= bus.data_in;
                if (last_elem) begin
                    row <= '0;
                    col <= '0;
                end else if (col == n_lat - 3'd1) begin
                    col <= '0;
                    row <= row + 3'd1;
                end else begin
                    col <= col + 3'd1;
                end
            end
        end
    end

    assign bus.A_flat     = a_q;
    assign bus.B_flat     = b_q;
    assign bus.size_error = size_error_q;
endmodule
